sram_bist_march: RTL and testbench
==================================

# sram_bist_march

Parametrised SRAM built-in self-test engine; successor to the single-pattern write/read BIST. Drives the external SRAM port through the same address/write-data/we_n/read-data interface and runs one of three selectable test algorithms over the full address space: address-as-data, checkerboard, or a 4-element march. Reports a sticky mismatch, a saturating error count and the first failing address, then signals finish.

## Interface
- ADDR_WIDTH, 18: SRAM address width; depth N = 2^ADDR_WIDTH.
- DATA_WIDTH, 16: SRAM word width; must be even.
- READ_LATENCY, 2: cycles from address presented (we_n=1) to valid BIST_read_data; must be ≥1.
- ERR_WIDTH, 16: width of the error counter.

- Clock  in  1  system clock; all logic on rising edge.
- Resetn  in  1  synchronous, active-low reset.
- BIST_start  in  1  rising edge launches a run (ignored while busy).
- BIST_mode  in  2  algorithm select; sampled on the start edge.
- BIST_address  out  ADDR_WIDTH  SRAM address (registered).
- BIST_write_data  out  DATA_WIDTH  SRAM write data (registered).
- BIST_we_n  out  1  SRAM write enable, active low (registered).
- BIST_read_data  in  DATA_WIDTH  SRAM read data.
- BIST_finish  out  1  high when idle/complete.
- BIST_mismatch  out  1  sticky: ≥1 compare failed this run.
- BIST_error_count  out  ERR_WIDTH  failed compares, saturating at all-ones.
- BIST_first_fail_address  out  ADDR_WIDTH  address of first failed compare.

## Operation
- Start: BIST_start & ~start_buf in S_IDLE. start_buf resets to 1, so a start held high through reset does not launch; a fresh rising edge is required.
- On start: latch mode; clear mismatch, error_count, first_fail_address; finish←0; enter S_RUN at element 0.
- Modes (elements run back-to-back; up = 0→N-1, down = N-1→0):
  - 00 ADDR: W(addr zero-extended/truncated to DATA_WIDTH) up; R(same) up.
  - 01 CHECKER: W(P) up; R(P) up; P = {DATA_WIDTH/2{2'b01}} (0x5555) when addr[0]=0, else {DATA_WIDTH/2{2'b10}} (0xAAAA).
  - 10 MARCH: W0 up; R0,W1 up; R1,W0 down; R0 up (0 = all-zeros, 1 = all-ones).
  - 11: reserved, executes as 00.
- W element: one cycle per address, we_n=0. R element: one cycle per address, we_n=1, write_data = expected. R,W element: two cycles per address, read cycle (we_n=1) then write cycle (we_n=0) at the same address.
- Each read cycle pushes {valid, expected, address} into a READ_LATENCY-deep pipe; on valid output, compare with BIST_read_data. On mismatch: mismatch←1; error_count+1 unless all-ones; first_fail_address captured only if mismatch was 0 before this compare.
- After the last access of the last element: S_DRAIN for READ_LATENCY cycles (we_n=1), then S_IDLE, finish←1.
- States: S_IDLE → S_RUN (per element/address/phase counters) → S_DRAIN → S_IDLE.
- BIST_start and BIST_mode ignored outside S_IDLE.

## Timing
- Reset (Resetn low at a rising edge): address 0, write_data 0, we_n 1, finish 0, mismatch 0, error_count 0, first_fail_address 0, state S_IDLE, compare pipe cleared. finish rises on the first idle cycle after reset release.
- Reset mid-run aborts immediately; no in-flight compare is taken.
- First access (address 0, we_n=0) on the first edge after the start edge is detected.
- Access count A: modes 00/01/11 = 2N; mode 10 = 6N. finish rises A+READ_LATENCY+1 cycles after the start-detect edge.
- Address wrap: up elements stop at N-1, down elements stop at 0; counters never wrap into the next element.
- Simultaneous: compare of the final read and finish assertion never coincide; the final compare completes in S_DRAIN.

## Structure
- Package bist_pkg: state enum (S_IDLE, S_RUN, S_DRAIN), mode enum (ADDR, CHECKER, MARCH), element-op enum (W, R, RW), pattern-function helpers.
- Sub-module bist_compare_pipe: READ_LATENCY-deep shift of {valid, expected, address}, comparator, mismatch/count/first-fail registers.

## Test plan
- ADDR_WIDTH=4, mode 00, fault-free SRAM model (latency 2) -> 32 accesses, finish high 35 cycles after start edge, mismatch 0, count 0.
- Mode 01, bit 3 of address 5 stuck-at-0 -> mismatch 1, count 1, first_fail_address 5 (expected 0xAAAA, read 0xAAA2).
- Mode 10 fault-free -> 96 accesses; element 2 address sequence 15..0 alternating we_n 1/0 with write_data 0x0000; mismatch 0.
- Mode 10, address 7 word stuck-at-0 -> only element 2 read fails: count 1, first_fail 7.
- Mode 00, every word stuck-at-1, ERR_WIDTH=4 -> 16 failures, count saturates at 15, first_fail 0.
- Reset mid element 1 with BIST_start held high -> next edge we_n 1, address 0, finish 0; no relaunch until start falls and rises; new run starts with cleared status.

Source files
------------

// File: rtl/sram_bist_march_pkg.sv
// Shared types for the SRAM march BIST: FSM states, algorithm modes,
// per-element operation descriptors and the element lookup tables.
package bist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'b00,
    MODE_CHECKER = 2'b01,
    MODE_MARCH   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {OP_W, OP_R, OP_RW} op_e;

  typedef enum logic [1:0] {P_ZERO, P_ONE, P_ADDR, P_CHK} pat_e;

  typedef struct packed {
    op_e  op;
    logic down;
    pat_e rd_pat;
    pat_e wr_pat;
  } elem_t;

  // Code 2'b11 is reserved and runs the address-as-data algorithm.
  function automatic mode_e decode_mode(logic [1:0] m);
    case (m)
      2'b01:   return MODE_CHECKER;
      2'b10:   return MODE_MARCH;
      default: return MODE_ADDR;
    endcase
  endfunction

  function automatic logic [1:0] last_elem(mode_e m);
    return (m == MODE_MARCH) ? 2'd3 : 2'd1;
  endfunction

  function automatic elem_t elem_desc(mode_e m, logic [1:0] idx);
    elem_t e;
    e = '{OP_W, 1'b0, P_ADDR, P_ADDR};
    case (m)
      MODE_MARCH: begin
        case (idx)
          2'd0:    e = '{OP_W,  1'b0, P_ZERO, P_ZERO};
          2'd1:    e = '{OP_RW, 1'b0, P_ZERO, P_ONE};
          2'd2:    e = '{OP_RW, 1'b1, P_ONE,  P_ZERO};
          default: e = '{OP_R,  1'b0, P_ZERO, P_ZERO};
        endcase
      end
      MODE_CHECKER: e = '{(idx == 2'd0) ? OP_W : OP_R, 1'b0, P_CHK, P_CHK};
      default:      e = '{(idx == 2'd0) ? OP_W : OP_R, 1'b0, P_ADDR, P_ADDR};
    endcase
    return e;
  endfunction

  function automatic logic elem_is_down(mode_e m, logic [1:0] idx);
    elem_t e;
    e = elem_desc(m, idx);
    return e.down;
  endfunction

endpackage

// File: rtl/sram_bist_march_if.sv
// SRAM-side port of the BIST engine: registered address/data/we_n out,
// read data back.
interface sram_bist_march_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] BIST_address;
  logic [DATA_WIDTH-1:0] BIST_write_data;
  logic                  BIST_we_n;
  logic [DATA_WIDTH-1:0] BIST_read_data;

  modport master (
    output BIST_address, BIST_write_data, BIST_we_n,
    input  BIST_read_data
  );

  modport slave (
    input  BIST_address, BIST_write_data, BIST_we_n,
    output BIST_read_data
  );
endinterface

// File: rtl/sram_bist_march_compare_pipe.sv
// Delays {valid, expected, address} of each read to line up with the SRAM
// read data, then compares and keeps the sticky/saturating status.
module bist_compare_pipe #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  clr_i,
  input  logic                  push_vld_i,
  input  logic [DATA_WIDTH-1:0] push_exp_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  mismatch_o,
  output logic [ERR_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_fail_o
);
  // Stage 0 is loaded on the same edge that drives the address onto the bus.
  localparam int STAGES = READ_LATENCY - 1;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] exp_pipe;
  logic [STAGES:0][ADDR_WIDTH-1:0] addr_pipe;

  logic                  hit;
  logic                  mm_d, mm_q;
  logic [ERR_WIDTH-1:0]  cnt_d, cnt_q;
  logic [ADDR_WIDTH-1:0] ff_d, ff_q;

  assign hit = vld_pipe[STAGES] && (exp_pipe[STAGES] != rdata_i);

  always_comb begin
    mm_d  = mm_q;
    cnt_d = cnt_q;
    ff_d  = ff_q;
    if (clr_i) begin
      mm_d  = 1'b0;
      cnt_d = '0;
      ff_d  = '0;
    end else if (hit) begin
      mm_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (!mm_q) ff_d = addr_pipe[STAGES];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      vld_pipe  <= '0;
      exp_pipe  <= '0;
      addr_pipe <= '0;
      mm_q      <= 1'b0;
      cnt_q     <= '0;
      ff_q      <= '0;
    end else begin
      vld_pipe[0]  <= push_vld_i;
      exp_pipe[0]  <= push_exp_i;
      addr_pipe[0] <= push_addr_i;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        exp_pipe[i]  <= exp_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      mm_q  <= mm_d;
      cnt_q <= cnt_d;
      ff_q  <= ff_d;
    end
  end

  assign mismatch_o   = mm_q;
  assign err_cnt_o    = cnt_q;
  assign first_fail_o = ff_q;

endmodule

// File: rtl/sram_bist_march.sv
// SRAM BIST engine: address-as-data, checkerboard or 4-element march over
// the full address space, with compare status and a finish flag.
module sram_bist_march
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  BIST_start,
  input  logic [1:0]            BIST_mode,
  sram_bist_march_if.master     sram,
  output logic                  BIST_finish,
  output logic                  BIST_mismatch,
  output logic [ERR_WIDTH-1:0]  BIST_error_count,
  output logic [ADDR_WIDTH-1:0] BIST_first_fail_address
);
  localparam int DRW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DRW-1:0]        DRAIN_LAST = DRW'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;

  state_e                state_d, state_q;
  mode_e                 mode_d, mode_q;
  logic [1:0]            elem_d, elem_q;
  logic [ADDR_WIDTH-1:0] caddr_d, caddr_q;
  logic                  phase_d, phase_q;
  logic [DRW-1:0]        drain_d, drain_q;
  logic                  start_buf_q;
  logic                  finish_d, finish_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic                  wen_d, wen_q;

  logic                  start_det, clr, push_vld, is_rd, nxt_down;
  elem_t                 desc;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] rd_val, wr_val;

  function automatic logic [DATA_WIDTH-1:0] pat_val(pat_e p, logic [ADDR_WIDTH-1:0] a);
    case (p)
      P_ZERO:  return '0;
      P_ONE:   return '1;
      P_ADDR:  return DATA_WIDTH'(a);
      default: return a[0] ? {DATA_WIDTH/2{2'b10}} : {DATA_WIDTH/2{2'b01}};
    endcase
  endfunction

  assign start_det = BIST_start && !start_buf_q && (state_q == S_IDLE);
  assign desc      = elem_desc(mode_q, elem_q);
  assign nxt_down  = elem_is_down(mode_q, elem_q + 2'd1);
  // R,W elements read on phase 0 and write on phase 1 at the same address.
  assign is_rd     = (desc.op == OP_R) || ((desc.op == OP_RW) && !phase_q);
  assign last_addr = desc.down ? '0 : ADDR_MAX;
  assign rd_val    = pat_val(desc.rd_pat, caddr_q);
  assign wr_val    = pat_val(desc.wr_pat, caddr_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    elem_d   = elem_q;
    caddr_d  = caddr_q;
    phase_d  = phase_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b1;
    finish_d = 1'b0;
    clr      = 1'b0;
    push_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        finish_d = 1'b1;
        if (start_det) begin
          mode_d   = decode_mode(BIST_mode);
          elem_d   = 2'd0;
          caddr_d  = '0;
          phase_d  = 1'b0;
          finish_d = 1'b0;
          clr      = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        addr_d   = caddr_q;
        wen_d    = is_rd;
        wdata_d  = is_rd ? rd_val : wr_val;
        push_vld = is_rd;
        if ((desc.op == OP_RW) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (caddr_q == last_addr) begin
            if (elem_q == last_elem(mode_q)) begin
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              elem_d  = elem_q + 2'd1;
              caddr_d = nxt_down ? ADDR_MAX : '0;
            end
          end else begin
            caddr_d = desc.down ? caddr_q - 1'b1 : caddr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_IDLE;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // start_buf resets high so a start held through reset cannot launch a run.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_ADDR;
      elem_q      <= 2'd0;
      caddr_q     <= '0;
      phase_q     <= 1'b0;
      drain_q     <= '0;
      start_buf_q <= 1'b1;
      finish_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      caddr_q     <= caddr_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      start_buf_q <= BIST_start;
      finish_q    <= finish_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
    end
  end

  bist_compare_pipe #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .ERR_WIDTH   (ERR_WIDTH)
  ) u_cmp (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .clr_i       (clr),
    .push_vld_i  (push_vld),
    .push_exp_i  (rd_val),
    .push_addr_i (caddr_q),
    .rdata_i     (sram.BIST_read_data),
    .mismatch_o  (BIST_mismatch),
    .err_cnt_o   (BIST_error_count),
    .first_fail_o(BIST_first_fail_address)
  );

  assign sram.BIST_address    = addr_q;
  assign sram.BIST_write_data = wdata_q;
  assign sram.BIST_we_n       = wen_q;
  assign BIST_finish          = finish_q;

endmodule

// File: tb/tb_sram_bist_march.sv
// Bench for sram_bist_march: SRAM model with per-word stuck-at masks, a table
// of runs and a queue of expected bus accesses per run.
module tb_sram_bist_march;
  localparam int AW = 4, DW = 16, RL = 2, EW = 4, N = 16;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          BIST_start = 1'b0;
  logic [1:0]    BIST_mode = 2'b00;
  logic          BIST_finish, BIST_mismatch;
  logic [EW-1:0] BIST_error_count;
  logic [AW-1:0] BIST_first_fail_address;

  always #5 Clock = ~Clock;

  sram_bist_march_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_bist_march #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .ERR_WIDTH(EW)
  ) dut (
    .Clock                  (Clock),
    .Resetn                 (Resetn),
    .BIST_start             (BIST_start),
    .BIST_mode              (BIST_mode),
    .sram                   (bus),
    .BIST_finish            (BIST_finish),
    .BIST_mismatch          (BIST_mismatch),
    .BIST_error_count       (BIST_error_count),
    .BIST_first_fail_address(BIST_first_fail_address)
  );

  // Latency-2 SRAM: address of cycle t is read at the next edge, data valid in cycle t+1.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa0 [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] rd_q;

  always @(posedge Clock) begin
    if (!bus.BIST_we_n) mem[bus.BIST_address] <= bus.BIST_write_data;
    rd_q <= (mem[bus.BIST_address] & ~sa0[bus.BIST_address]) | sa1[bus.BIST_address];
  end
  assign bus.BIST_read_data = rd_q;

  typedef struct {
    logic [1:0]    mode;
    int            sa0_addr;
    logic [DW-1:0] sa0_mask;
    bit            sa1_all;
    bit            exp_mm;
    int            exp_cnt;
    int            exp_ffa;
  } run_t;

  run_t runs [6];
  logic [AW+DW:0] exp_q [$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_acc(input int a, input bit we_n, input logic [DW-1:0] d);
    exp_q.push_back({AW'(a), we_n, d});
  endtask

  task automatic gen_seq(input logic [1:0] m);
    exp_q.delete();
    if (m == 2'b10) begin
      for (int a = 0; a < N; a++) push_acc(a, 1'b0, 16'h0000);
      for (int a = 0; a < N; a++) begin
        push_acc(a, 1'b1, 16'h0000);
        push_acc(a, 1'b0, 16'hFFFF);
      end
      for (int a = N - 1; a >= 0; a--) begin
        push_acc(a, 1'b1, 16'hFFFF);
        push_acc(a, 1'b0, 16'h0000);
      end
      for (int a = 0; a < N; a++) push_acc(a, 1'b1, 16'h0000);
    end else if (m == 2'b01) begin
      for (int a = 0; a < N; a++) push_acc(a, 1'b0, (a % 2) ? 16'hAAAA : 16'h5555);
      for (int a = 0; a < N; a++) push_acc(a, 1'b1, (a % 2) ? 16'hAAAA : 16'h5555);
    end else begin
      for (int a = 0; a < N; a++) push_acc(a, 1'b0, 16'(a));
      for (int a = 0; a < N; a++) push_acc(a, 1'b1, 16'(a));
    end
  endtask

  task automatic set_faults(input run_t r);
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = r.sa1_all ? '1 : '0;
    end
    if (r.sa0_addr >= 0) sa0[r.sa0_addr] = r.sa0_mask;
  endtask

  task automatic do_run(input run_t r, input string tag);
    int a_cnt, cyc;
    logic [AW+DW:0] e, g;
    set_faults(r);
    gen_seq(r.mode);
    a_cnt = exp_q.size();
    BIST_mode  = r.mode;
    BIST_start = 1'b1;
    @(posedge Clock); #1;
    BIST_start = 1'b0;
    chk({tag, ".finish_low"}, 32'(BIST_finish), 32'd0);
    for (int k = 0; k < a_cnt; k++) begin
      @(posedge Clock); #1;
      e = exp_q.pop_front();
      g = {bus.BIST_address, bus.BIST_we_n, bus.BIST_write_data};
      chk($sformatf("%s.acc%0d", tag, k), 32'(g), 32'(e));
    end
    cyc = a_cnt;
    while (!BIST_finish && cyc < a_cnt + 40) begin
      @(posedge Clock); #1;
      cyc++;
    end
    chk({tag, ".finish_lat"}, 32'(cyc), 32'(a_cnt + RL + 1));
    chk({tag, ".mismatch"},   32'(BIST_mismatch), 32'(r.exp_mm));
    chk({tag, ".err_count"},  32'(BIST_error_count), 32'(r.exp_cnt));
    chk({tag, ".first_fail"}, 32'(BIST_first_fail_address), 32'(r.exp_ffa));
  endtask

  initial begin
    runs[0] = '{2'b00, -1, 16'h0000, 1'b0, 1'b0, 0,  0};
    runs[1] = '{2'b01,  5, 16'h0008, 1'b0, 1'b1, 1,  5};
    runs[2] = '{2'b10, -1, 16'h0000, 1'b0, 1'b0, 0,  0};
    runs[3] = '{2'b10,  7, 16'hFFFF, 1'b0, 1'b1, 1,  7};
    runs[4] = '{2'b00, -1, 16'h0000, 1'b1, 1'b1, 15, 0};
    runs[5] = '{2'b11, -1, 16'h0000, 1'b0, 1'b0, 0,  0};
    set_faults(runs[0]);

    repeat (3) @(posedge Clock);
    #1;
    chk("rst.address",    32'(bus.BIST_address), 32'd0);
    chk("rst.write_data", 32'(bus.BIST_write_data), 32'd0);
    chk("rst.we_n",       32'(bus.BIST_we_n), 32'd1);
    chk("rst.finish",     32'(BIST_finish), 32'd0);
    chk("rst.mismatch",   32'(BIST_mismatch), 32'd0);
    chk("rst.err_count",  32'(BIST_error_count), 32'd0);
    chk("rst.first_fail", 32'(BIST_first_fail_address), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    chk("rst.finish_rise", 32'(BIST_finish), 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_run(runs[i], $sformatf("run%0d", i));
      @(posedge Clock); #1;
    end

    // Abort a failing run in its read element with start held high.
    set_faults(runs[4]);
    BIST_mode  = 2'b00;
    BIST_start = 1'b1;
    @(posedge Clock); #1;
    repeat (20) @(posedge Clock);
    #1;
    chk("abort.pre_mismatch", 32'(BIST_mismatch), 32'd1);
    Resetn = 1'b0;
    @(posedge Clock); #1;
    chk("abort.we_n",      32'(bus.BIST_we_n), 32'd1);
    chk("abort.address",   32'(bus.BIST_address), 32'd0);
    chk("abort.finish",    32'(BIST_finish), 32'd0);
    chk("abort.mismatch",  32'(BIST_mismatch), 32'd0);
    chk("abort.err_count", 32'(BIST_error_count), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    chk("abort.finish_rise", 32'(BIST_finish), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clock); #1;
      chk($sformatf("abort.no_launch%0d", k), 32'({bus.BIST_we_n, BIST_finish}), 32'b11);
    end
    set_faults(runs[0]);
    BIST_start = 1'b0;
    @(posedge Clock); #1;
    do_run(runs[0], "relaunch");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
